// File: rtl/arcade_pkg.sv
// Shared definitions for the hiscore RAM arbiter: FSM state encoding and
// the default user-pause dim delay.
package arcade_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HALT    = 3'd1,
    WAIT_VB = 3'd2,
    GRANT   = 3'd3,
    RELEASE = 3'd4
  } arb_state_e;

  // 10 s of user pause at 12 MHz before the video is dimmed.
  localparam logic [31:0] DIM_CYCLES_DEFAULT = 32'h0727_0E00;

endpackage

// File: rtl/hiscore_ram_arbiter_if.sv
// Bus bundle between the hiscore engine, the game CPU and the shared work RAM.
// "slave" is the arbiter's view; "master" is the surrounding system's view.
interface hiscore_ram_arbiter_if #(
  parameter int AW = 12
) ();

  logic          hs_req;
  logic [AW-1:0] hs_addr;
  logic [7:0]    hs_wdata;
  logic          hs_we;
  logic          hs_gnt;
  logic [7:0]    hs_rdata;

  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_we;
  logic [7:0]    cpu_rdata;

  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_rdata;

  modport slave (
    input  hs_req, hs_addr, hs_wdata, hs_we,
    output hs_gnt, hs_rdata,
    input  cpu_addr, cpu_wdata, cpu_we,
    output cpu_rdata,
    output ram_addr, ram_wdata, ram_we,
    input  ram_rdata
  );

  modport master (
    output hs_req, hs_addr, hs_wdata, hs_we,
    input  hs_gnt, hs_rdata,
    output cpu_addr, cpu_wdata, cpu_we,
    input  cpu_rdata,
    input  ram_addr, ram_wdata, ram_we,
    output ram_rdata
  );

endinterface

// File: rtl/hiscore_ram_arbiter_pause_ctrl.sv
// User pause control: synchronises the pause button, toggles the user pause
// on each press and raises dim after the pause has been held long enough.
module pause_ctrl
  import arcade_pkg::*;
#(
  parameter logic [31:0] DIM_CYCLES = DIM_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pause_btn,
  output logic o_user_pause,
  output logic o_dim
);

  logic [1:0]  r_sync;
  logic        r_user_pause;
  logic [31:0] r_timer;
  logic        r_dim;
  logic [31:0] w_timer_next;

  // Dim timer: counts only while the user pause is active, parks at the limit.
  always_comb begin
    w_timer_next = 32'd0;
    if (r_user_pause) begin
      if (r_timer >= DIM_CYCLES) begin
        w_timer_next = DIM_CYCLES;
      end else begin
        w_timer_next = r_timer + 32'd1;
      end
    end else begin
      w_timer_next = 32'd0;
    end
  end

  // Button synchroniser, press-to-toggle user pause, timer and registered dim.
  // The press is detected between the two synchroniser stages so the pause
  // reaches the core output three cycles after the button goes high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync       <= 2'b00;
      r_user_pause <= 1'b0;
      r_timer      <= 32'd0;
      r_dim        <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pause_btn};
      if (r_sync[0] && !r_sync[1]) begin
        r_user_pause <= ~r_user_pause;
      end else begin
        r_user_pause <= r_user_pause;
      end
      r_timer <= w_timer_next;
      r_dim   <= (w_timer_next == DIM_CYCLES);
    end
  end

  assign o_user_pause = r_user_pause;
  assign o_dim        = r_dim;

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// Hiscore RAM arbiter: pauses the game core, waits for the core to settle
// and for vertical blank, then hands the shared work RAM to the hiscore
// engine until it lets go. The CPU owns the RAM at all other times.
module hiscore_ram_arbiter
  import arcade_pkg::*;
#(
  parameter int          AW         = 12,
  parameter int          SETTLE     = 4,
  parameter logic [31:0] DIM_CYCLES = DIM_CYCLES_DEFAULT
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  pause_btn,
  input  logic                  vblank,
  hiscore_ram_arbiter_if.slave  bus,
  output logic                  pause,
  output logic                  dim
);

  localparam int             SCW         = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE);

  arb_state_e     r_state;
  logic [SCW-1:0] r_settle;
  logic           r_rel;
  logic           r_hs_gnt;
  logic           r_pause;

  logic           w_user_pause;
  logic           w_dim;
  logic [AW-1:0]  w_ram_addr;
  logic [7:0]     w_ram_wdata;
  logic           w_ram_we;

  pause_ctrl #(
    .DIM_CYCLES (DIM_CYCLES)
  ) u_pause_ctrl (
    .i_clk        (clk_sys),
    .i_rst_n      (reset_n),
    .i_pause_btn  (pause_btn),
    .o_user_pause (w_user_pause),
    .o_dim        (w_dim)
  );

  // Arbitration FSM with registered grant and core pause. The grant drops on
  // the same edge the FSM leaves GRANT so the engine never owns the RAM in
  // RELEASE. A hs_req drop before the grant aborts without ever granting.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_settle <= '0;
      r_rel    <= 1'b0;
      r_hs_gnt <= 1'b0;
      r_pause  <= 1'b0;
    end else begin
      r_hs_gnt <= (r_state == GRANT) && bus.hs_req;
      r_pause  <= w_user_pause | (r_state != IDLE);
      case (r_state)
        IDLE: begin
          r_settle <= '0;
          r_rel    <= 1'b0;
          if (bus.hs_req) begin
            r_state <= HALT;
          end else begin
            r_state <= IDLE;
          end
        end
        HALT: begin
          if (!bus.hs_req) begin
            r_state <= RELEASE;
            r_rel   <= 1'b0;
          end else if (r_settle == SETTLE_LAST) begin
            r_state <= vblank ? GRANT : WAIT_VB;
          end else begin
            r_settle <= r_settle + SCW'(1);
          end
        end
        WAIT_VB: begin
          if (!bus.hs_req) begin
            r_state <= RELEASE;
            r_rel   <= 1'b0;
          end else if (vblank) begin
            r_state <= GRANT;
          end else begin
            r_state <= WAIT_VB;
          end
        end
        GRANT: begin
          if (!bus.hs_req) begin
            r_state <= RELEASE;
            r_rel   <= 1'b0;
          end else begin
            r_state <= GRANT;
          end
        end
        RELEASE: begin
          if (r_rel) begin
            r_state <= IDLE;
            r_rel   <= 1'b0;
          end else begin
            r_rel <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // RAM port mux: engine while granted, otherwise CPU with writes blocked
  // whenever the core is paused.
  always_comb begin
    w_ram_addr  = bus.cpu_addr;
    w_ram_wdata = bus.cpu_wdata;
    w_ram_we    = 1'b0;
    if (r_hs_gnt) begin
      w_ram_addr  = bus.hs_addr;
      w_ram_wdata = bus.hs_wdata;
      w_ram_we    = bus.hs_we & bus.hs_req;
    end else begin
      w_ram_addr  = bus.cpu_addr;
      w_ram_wdata = bus.cpu_wdata;
      w_ram_we    = bus.cpu_we & ~r_pause;
    end
  end

  assign bus.ram_addr  = w_ram_addr;
  assign bus.ram_wdata = w_ram_wdata;
  assign bus.ram_we    = w_ram_we;
  assign bus.hs_gnt    = r_hs_gnt;
  assign bus.hs_rdata  = bus.ram_rdata;
  assign bus.cpu_rdata = bus.ram_rdata;
  assign pause         = r_pause;
  assign dim           = w_dim;

endmodule
